proc_control: RTL and testbench

PROC_CONTROL -- requirements
Module: proc_control

---
 rtl/proc_pkg.sv | 16 +
 rtl/dec3to8.sv | 8 +
 rtl/proc_control.sv | 113 +++++++++++
 tb/tb_proc_control.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared word width, opcode and step encodings for the processor control unit.
package proc_pkg;
    localparam int W = 9;
    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011
    } op_e;
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;
endpackage

// File: rtl/dec3to8.sv
// dec3to8: 3-to-8 one-hot decoder; w_i selects the hot bit, en_i low forces all zeros.
module dec3to8 (
    input  logic [2:0] w_i,
    input  logic       en_i,
    output logic [7:0] y_o
);
    assign y_o = en_i ? 8'b1 << w_i : '0;
endmodule

// File: rtl/proc_control.sv
// proc_control: Moore control FSM (T0..T3) for a 9-bit mv/mvi/add/sub processor.
// Inputs: clk, rst (async, active-high), Run (start, sampled in T0), Din (instruction word in T0).
// Outputs: R0in..R7in, Ain, Gin load enables; R0out..R7out, Gout, Dinout bus selects;
//          AddSub, Done, IR (instruction register), Tstep (current step).
module proc_control
    import proc_pkg::*;
#(
    parameter int W = proc_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Run,
    input  logic [W-1:0] Din,
    output logic         R0in,
    output logic         R1in,
    output logic         R2in,
    output logic         R3in,
    output logic         R4in,
    output logic         R5in,
    output logic         R6in,
    output logic         R7in,
    output logic         Ain,
    output logic         Gin,
    output logic         R0out,
    output logic         R1out,
    output logic         R2out,
    output logic         R3out,
    output logic         R4out,
    output logic         R5out,
    output logic         R6out,
    output logic         R7out,
    output logic         Gout,
    output logic         Dinout,
    output logic         AddSub,
    output logic         Done,
    output logic [W-1:0] IR,
    output logic [1:0]   Tstep
);
    step_e        state_q, state_d;
    logic [W-1:0] ir_q, ir_d;
    logic [2:0]   op;
    logic         rx_in, rx_out, ry_out;
    logic [7:0]   x_sel, y_sel, r_in, r_out;

    assign op = ir_q[W-1 -: 3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs depend only on state_q and ir_q; Run only steers the T0 transition.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        rx_in   = 1'b0;
        rx_out  = 1'b0;
        ry_out  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        Dinout  = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;
        case (state_q)
            T0: if (Run) begin
                ir_d    = Din;
                state_d = T1;
            end
            T1: if (op == OP_ADD || op == OP_SUB) begin
                rx_out  = 1'b1;
                Ain     = 1'b1;
                state_d = T2;
            end else begin
                // mv, mvi and the NOP opcodes all finish here
                ry_out  = op == OP_MV;
                Dinout  = op == OP_MVI;
                rx_in   = op == OP_MV || op == OP_MVI;
                Done    = 1'b1;
                state_d = T0;
            end
            T2: begin
                ry_out  = 1'b1;
                Gin     = 1'b1;
                AddSub  = op == OP_SUB;
                state_d = T3;
            end
            T3: begin
                Gout    = 1'b1;
                rx_in   = 1'b1;
                Done    = 1'b1;
                state_d = T0;
            end
        endcase
    end

    dec3to8 u_dec_x (.w_i(ir_q[5:3]), .en_i(1'b1),  .y_o(x_sel));
    dec3to8 u_dec_y (.w_i(ir_q[2:0]), .en_i(ry_out), .y_o(y_sel));

    // Rx drives the bus only in T1 of add/sub, never in the same cycle as Ry.
    assign r_in  = rx_in ? x_sel : '0;
    assign r_out = y_sel | (rx_out ? x_sel : '0);

    assign {R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in}         = r_in;
    assign {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = r_out;
    assign IR    = ir_q;
    assign Tstep = state_q;
endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: table-driven and scoreboard checks of proc_control driving a behavioural datapath.
module tb_proc_control;
    logic       clk = 1'b0;
    logic       rst, Run;
    logic [8:0] Din;
    logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in, Ain, Gin;
    logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out, Gout, Dinout;
    logic AddSub, Done;
    logic [8:0] IR;
    logic [1:0] Tstep;

    proc_control #(.W(9)) dut (
        .clk(clk), .rst(rst), .Run(Run), .Din(Din),
        .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in),
        .R4in(R4in), .R5in(R5in), .R6in(R6in), .R7in(R7in),
        .Ain(Ain), .Gin(Gin),
        .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out),
        .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
        .Gout(Gout), .Dinout(Dinout), .AddSub(AddSub), .Done(Done),
        .IR(IR), .Tstep(Tstep)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] rin;
        logic [7:0] rout;
        logic ain, gin, gout, dinout, addsub, done;
    } ctrl_t;

    ctrl_t act;
    assign act = {{R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in},
                  {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out},
                  Ain, Gin, Gout, Dinout, AddSub, Done};

    logic [8:0] rf [8];
    logic [8:0] a_q, g_q, bus;

    always_comb begin
        bus = '0;
        if (Dinout) bus = Din;
        if (Gout) bus = bus | g_q;
        for (int i = 0; i < 8; i++) if (act.rout[i]) bus = bus | rf[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (act.rin[i]) rf[i] <= bus;
        if (Ain) a_q <= bus;
        if (Gin) g_q <= AddSub ? a_q - bus : a_q + bus;
    end

    function automatic ctrl_t exp_ctrl(logic [8:0] ir, int t);
        ctrl_t c = '0;
        logic [2:0] op = ir[8:6];
        logic [2:0] x = ir[5:3];
        logic [2:0] y = ir[2:0];
        if (t == 1) begin
            if (op == 3'b000) begin c.rout[y] = 1'b1; c.rin[x] = 1'b1; c.done = 1'b1; end
            else if (op == 3'b001) begin c.dinout = 1'b1; c.rin[x] = 1'b1; c.done = 1'b1; end
            else if (op == 3'b010 || op == 3'b011) begin c.rout[x] = 1'b1; c.ain = 1'b1; end
            else c.done = 1'b1;
        end else if (t == 2) begin
            c.rout[y] = 1'b1; c.gin = 1'b1; c.addsub = op == 3'b011;
        end else if (t == 3) begin
            c.gout = 1'b1; c.rin[x] = 1'b1; c.done = 1'b1;
        end
        return c;
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    task automatic chk_onehot();
        chk("bus_onehot", 32'($countones({act.rout, Gout, Dinout}) <= 1), 1);
        chk("rin_onehot", 32'($countones(act.rin) <= 1), 1);
    endtask

    typedef struct {
        logic [8:0] instr;
        logic [8:0] imm;
        int         rx;
        logic [8:0] val;
        int         lat;
    } vec_t;

    typedef struct {
        int         rx;
        logic [8:0] val;
        int         lat;
    } sb_t;

    sb_t sb[$];

    // Called at a negedge with the DUT in T0; returns at the negedge after the writeback edge.
    task automatic run_instr(vec_t v);
        int   done_k = 0;
        sb_t  e;
        chk("t0_step", 32'(Tstep), 0);
        chk("t0_ctrl", 32'(act), 0);
        Run = 1'b1;
        Din = v.instr;
        sb.push_back('{v.rx, v.val, v.lat});
        @(negedge clk);
        Run = 1'b0;
        Din = v.imm;
        chk("ir_capture", 32'(IR), 32'(v.instr));
        for (int k = 1; k <= 3; k++) begin
            chk("step", 32'(Tstep), 32'(k));
            chk("ctrl", 32'(act), 32'(exp_ctrl(v.instr, k)));
            chk_onehot();
            if (Done) begin
                done_k = k;
                break;
            end
            @(negedge clk);
        end
        if (done_k == 0) chk("done_timeout", 0, 1);
        @(negedge clk);
        e = sb.pop_front();
        chk("latency", 32'(done_k), 32'(e.lat));
        chk("reg_value", 32'(rf[e.rx]), 32'(e.val));
    endtask

    vec_t vt[12];
    localparam logic [8:0] NOP_I = 9'b111_010_011;
    localparam logic [8:0] MVI4  = 9'b001_100_000;

    initial begin
        vt[0]  = '{9'b001_000_000, 9'd5,   0, 9'd5,   1};
        vt[1]  = '{9'b000_001_000, 9'd0,   1, 9'd5,   1};
        vt[2]  = '{9'b010_000_001, 9'd0,   0, 9'd10,  3};
        vt[3]  = '{9'b011_000_001, 9'd0,   0, 9'd5,   3};
        vt[4]  = '{9'b001_010_000, 9'd7,   2, 9'd7,   1};
        vt[5]  = '{9'b010_010_010, 9'd0,   2, 9'd14,  3};
        vt[6]  = '{9'b001_011_000, 9'd100, 3, 9'd100, 1};
        vt[7]  = '{9'b000_011_011, 9'd0,   3, 9'd100, 1};
        vt[8]  = '{9'b001_111_000, 9'd3,   7, 9'd3,   1};
        vt[9]  = '{9'b011_111_010, 9'd0,   7, 9'd501, 3};
        vt[10] = '{NOP_I,          9'd0,   2, 9'd14,  1};
        vt[11] = '{9'b101_000_001, 9'd0,   0, 9'd5,   1};

        rst = 1'b1;
        Run = 1'b0;
        Din = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_step", 32'(Tstep), 0);
        chk("rst_ir", 32'(IR), 0);
        chk("rst_ctrl", 32'(act), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i]) run_instr(vt[i]);

        // abort add R0,R1 in T2: outputs must drop at once and R0 must keep 5
        Run = 1'b1;
        Din = 9'b010_000_001;
        @(negedge clk);
        Run = 1'b0;
        @(negedge clk);
        chk("abort_pre_step", 32'(Tstep), 2);
        rst = 1'b1;
        #1;
        chk("abort_step", 32'(Tstep), 0);
        chk("abort_ir", 32'(IR), 0);
        chk("abort_ctrl", 32'(act), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_step", 32'(Tstep), 0);
        chk("post_rst_rin", 32'(act.rin), 0);
        chk("abort_r0", 32'(rf[0]), 5);

        // NOP then mvi R4,42 with Run held: no capture during Done, capture in the next T0
        Run = 1'b1;
        Din = NOP_I;
        @(negedge clk);
        chk("nop_ctrl", 32'(act), 32'(exp_ctrl(NOP_I, 1)));
        chk_onehot();
        Din = MVI4;
        @(negedge clk);
        chk("ovl_t0_step", 32'(Tstep), 0);
        chk("ovl_t0_ir", 32'(IR), 32'(NOP_I));
        chk("ovl_t0_ctrl", 32'(act), 0);
        @(negedge clk);
        chk("ovl_t1_step", 32'(Tstep), 1);
        chk("ovl_t1_ir", 32'(IR), 32'(MVI4));
        chk("ovl_t1_ctrl", 32'(act), 32'(exp_ctrl(MVI4, 1)));
        chk_onehot();
        Run = 1'b0;
        Din = 9'd42;
        @(negedge clk);
        chk("ovl_r4", 32'(rf[4]), 42);
        chk("ovl_end_step", 32'(Tstep), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
